midi_uart_rx: RTL and testbench

MIDI_UART_RX -- requirements
Module: midi_uart_rx

---
 rtl/midi_uart_rx.sv | 142 ++++++++++++++
 tb/tb_midi_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_rx.sv
// MIDI 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
// Optional MIDI_RX_REALTIME_FILTER_EN drops system real-time bytes (F8..FF).
module midi_uart_rx #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 31250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       midi_rx,
   output logic [7:0] midi_data,
   output logic       midi_valid,
   output logic       framing_error
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TW           = $clog2(CLKS_PER_BIT);

   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic          sync1_q, sync2_q;
   logic [2:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          line;
   logic          accept;

   assign line = sync2_q;

`ifdef MIDI_RX_REALTIME_FILTER_EN
   assign accept = (shift_q[7:3] != 5'b11111);
`else
   assign accept = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (!line) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (timer_q == HALF_LAST) begin
               timer_d   = '0;
               bit_idx_d = '0;
               state_d   = line ? S_IDLE : S_DATA;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_DATA: begin
            if (timer_q == BIT_LAST) begin
               timer_d            = '0;
               shift_d[bit_idx_q] = line;
               bit_idx_d          = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_STOP: begin
            if (timer_q == BIT_LAST) begin
               timer_d = '0;
               if (line) begin
                  state_d = S_IDLE;
                  if (accept) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  state_d = S_WAIT_IDLE;
                  ferr_d  = 1'b1;
               end
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WAIT_IDLE: begin
            // A held-low line is a break; wait for it to end before rearming.
            timer_d = '0;
            if (line) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         sync1_q   <= midi_rx;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         ferr_q    <= ferr_d;
      end
   end

   assign midi_data     = data_q;
   assign midi_valid    = valid_q;
   assign framing_error = ferr_q;

endmodule

// File: tb/tb_midi_uart_rx.sv
// Directed bench for midi_uart_rx at 32 clocks per bit.
// Expected bytes go into a scoreboard queue that the output monitor drains.
module tb_midi_uart_rx;

   localparam int CPB = 32;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       midi_rx = 1'b1;
   logic [7:0] midi_data;
   logic       midi_valid;
   logic       framing_error;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int cyc = 0;
   int last_valid_cyc = 0;
   logic [7:0] exp_q[$];

   midi_uart_rx #(
      .CLK_FREQ(1_000_000),
      .BAUD    (31250)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .midi_rx      (midi_rx),
      .midi_data    (midi_data),
      .midi_valid   (midi_valid),
      .framing_error(framing_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (midi_valid || framing_error) begin
            checks++;
            assert (!(midi_valid && framing_error)) else begin
               errors++;
               $error("FAIL strobe_overlap valid=%0b ferr=%0b required not both", midi_valid, framing_error);
            end
         end
         if (framing_error) ferr_cnt++;
         if (midi_valid) begin
            logic [7:0] exp;
            valid_cnt++;
            last_valid_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $error("FAIL unexpected_byte got=%02h required none", midi_data);
            end else begin
               exp = exp_q.pop_front();
               assert (midi_data === exp) else begin
                  errors++;
                  $error("FAIL byte_data got=%02h required=%02h", midi_data, exp);
               end
            end
         end
      end
   end

   task automatic hold(input logic v, input int n);
      midi_rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop, CPB);
      midi_rx = 1'b1;
   endtask

   task automatic check(input string tag, input int got, input int req);
      checks++;
      assert (got === req) else begin
         errors++;
         $error("FAIL %s got=%0d required=%0d", tag, got, req);
      end
   endtask

   initial begin
      int v0, f0, t0;
      // reset and idle
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_data", midi_data, 0);
      check("rst_valid", midi_valid, 0);
      check("rst_ferr", framing_error, 0);
      reset = 1'b0;
      hold(1'b1, 500);
      check("idle_valid_cnt", valid_cnt, 0);
      check("idle_ferr_cnt", ferr_cnt, 0);

      // single byte with latency
      exp_q.push_back(8'h90);
      t0 = cyc;
      send_byte(8'h90, 1'b1);
      hold(1'b1, 40);
      check("single_cnt", valid_cnt, 1);
      checks++;
      assert (last_valid_cyc - t0 >= 305 && last_valid_cyc - t0 <= 309) else begin
         errors++;
         $error("FAIL latency got=%0d required=307+-2", last_valid_cyc - t0);
      end

      // back-to-back
      v0 = valid_cnt;
      f0 = ferr_cnt;
      exp_q.push_back(8'h90);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h7F);
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h7F, 1'b1);
      hold(1'b1, 60);
      check("b2b_cnt", valid_cnt - v0, 3);
      check("b2b_ferr", ferr_cnt - f0, 0);
      check("b2b_queue", exp_q.size(), 0);

      // glitch
      v0 = valid_cnt;
      f0 = ferr_cnt;
      hold(1'b0, 10);
      hold(1'b1, 100);
      check("glitch_valid", valid_cnt - v0, 0);
      check("glitch_ferr", ferr_cnt - f0, 0);

      // bad stop bit
      send_byte(8'h12, 1'b0);
      hold(1'b1, 60);
      check("frame_ferr", ferr_cnt - f0, 1);
      check("frame_valid", valid_cnt - v0, 0);
      check("frame_data_hold", midi_data, 8'h7F);

      // break then byte
      v0 = valid_cnt;
      f0 = ferr_cnt;
      hold(1'b0, 1000);
      hold(1'b1, 100);
      check("break_valid", valid_cnt - v0, 0);
      check("break_ferr", ferr_cnt - f0, 1);
      exp_q.push_back(8'h45);
      send_byte(8'h45, 1'b1);
      hold(1'b1, 60);
      check("after_break_cnt", valid_cnt - v0, 1);
      check("after_break_data", midi_data, 8'h45);

      // realtime byte then status byte
      v0 = valid_cnt;
`ifdef MIDI_RX_REALTIME_FILTER_EN
      exp_q.push_back(8'h80);
`else
      exp_q.push_back(8'hF8);
      exp_q.push_back(8'h80);
`endif
      send_byte(8'hF8, 1'b1);
      send_byte(8'h80, 1'b1);
      hold(1'b1, 60);
`ifdef MIDI_RX_REALTIME_FILTER_EN
      check("rt_cnt", valid_cnt - v0, 1);
`else
      check("rt_cnt", valid_cnt - v0, 2);
`endif
      check("rt_queue", exp_q.size(), 0);

      // reset in the middle of bit 4 of AA
      v0 = valid_cnt;
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(i[0], CPB);
      hold(1'b0, CPB / 2);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      midi_rx = 1'b1;
      check("mid_rst_data", midi_data, 0);
      hold(1'b1, 100);
      check("mid_rst_hold", midi_data, 0);
      check("mid_rst_none", valid_cnt - v0, 0);
      exp_q.push_back(8'h55);
      send_byte(8'h55, 1'b1);
      hold(1'b1, 60);
      check("mid_rst_cnt", valid_cnt - v0, 1);
      check("mid_rst_byte", midi_data, 8'h55);
      check("final_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
